hazard_unit_fwd: RTL and testbench
==================================

// Module: hazard_unit_fwd
// PURPOSE
//  Next-generation pipeline hazard unit for the 5-stage RV32I core (IF/ID/EX/MA/WB).
//  Adds operand forwarding selects, load-use detection with EX bubble insertion, and a
//  multi-cycle branch-penalty FSM. Adds a selectable predict-not-taken flush mode and a
//  saturating stall-cycle performance counter. Sits beside the datapath and drives every
//  stage clock enable plus the ID operand-mux selects.
// PARAMETERS
//  NREG           32  architectural register count; REG_W = $clog2(NREG)
//  FWD_EN         1   1: forward from EX/MA/WB; 0: stall on any RAW match in EX/MA
//  BRANCH_PENALTY 1   IF/ID stall cycles after a branch in ID (BR_MODE=0), range 1..7
//  BR_MODE        0   0: stall on branch; 1: predict-not-taken, flush IF/ID on taken
//  CNT_W          32  width of the stall-cycle counter
// PORTS
//  i_clk            in   1      core clock
//  i_rst            in   1      asynchronous reset, active-high
//  i_instr_ready    in   1      IF fetch data valid
//  i_data_ready     in   1      MA load/store complete (low = memory wait)
//  i_id_rs1/rs2     in   REG_W  ID source registers
//  i_id_use_rs1/2   in   1      ID instruction actually reads rs1/rs2
//  i_id_branch      in   1      ID holds a branch/jump
//  i_ex_rd,i_ma_rd,i_wb_rd in REG_W destination registers per stage
//  i_ex_we,i_ma_we,i_wb_we in 1  stage writes its rd
//  i_ex_is_load     in   1      EX holds a load
//  i_ex_br_taken    in   1      branch resolved taken in EX (BR_MODE=1 only)
//  o_if/id/ex/ma/wb_clk_en out 1 per-stage clock enables
//  o_ex_bubble      out  1      ID->EX register loads a NOP this cycle
//  o_flush          out  1      IF/ID registers cleared to NOP (BR_MODE=1)
//  o_fwd_rs1/rs2    out  2      00 regfile, 01 EX, 10 MA, 11 WB
//  o_stall_cycles   out  CNT_W  cycles with o_if_clk_en=0, saturating
// BEHAVIOUR
//  - While i_rst=1: all clk_en=0, bubble/flush=0, fwd sels=00, FSM=RUN, counters=0.
//  - Register x0 never matches; a source matches only if its use flag and the stage we are set.
//  - Forwarding (FWD_EN=1): youngest match wins, EX>MA>WB; an EX match with i_ex_is_load
//    gives sel 00 and raises a load-use stall. FWD_EN=0: sels stay 00; any EX/MA match stalls.
//  - Priority (highest first):
//    1 MEM_WAIT (!i_data_ready): all five enables 0, bubble 0, FSM and counters frozen.
//    2 LOAD_USE/RAW: IF,ID enable 0; EX,MA,WB enable 1; o_ex_bubble=1. Exactly one cycle
//      for a load-use (the load moves to MA and then forwards).
//    3 BRANCH, BR_MODE=0: a branch in ID advances normally, and in the same cycle FSM RUN->BR_WAIT with
//      cnt=BRANCH_PENALTY. In BR_WAIT: IF,ID enable 0, bubble 1, cnt-- per unfrozen cycle,
//      back to RUN when cnt reaches 0. Branch entry is ignored while already in BR_WAIT.
//    4 FETCH_WAIT (!i_instr_ready): IF,ID enable 0, bubble 1.
//  - BR_MODE=1: FSM stays in RUN. i_ex_br_taken gives o_flush=1 for one cycle and bubble=1.
//    Flush beats LOAD_USE, the stale ID instruction is discarded, and IF stays enabled to load
//    the target. Flush is suppressed under MEM_WAIT and asserts on the first unfrozen cycle
//    after it. i_ex_br_taken is held by the datapath while frozen.
//  - o_stall_cycles increments on every cycle with o_if_clk_en=0 outside reset and
//    holds at 2^CNT_W-1.
//  - Latency: all enables, sels, bubble and flush are combinational from inputs and
//    registered FSM state, with no cycle delay. FSM and counter update on posedge i_clk.
//  - Asserting reset mid-BR_WAIT aborts the penalty immediately, with no residual stall after release.
// STRUCTURE
//  - hazard_pkg holds fwd_sel_e (FWD_RF, FWD_EX, FWD_MA, FWD_WB), br_state_e (BR_RUN,
//    BR_WAIT) and stall_cause_e (NONE, MEM_WAIT, LOAD_USE, BRANCH, FETCH_WAIT).
//  - Sub-module hazard_fwd_sel (one source register to a fwd sel plus a load-use flag) is
//    instantiated twice. The top module holds the priority encoder, branch FSM and counter.
// TESTING
//  1 ID rs1=5 use, EX rd=5 we, not load -> o_fwd_rs1=01, all enables 1, no bubble.
//  2 EX lw rd=7, ID rs2=7 -> one cycle with IF/ID en=0 and bubble=1; next cycle fwd_rs2=10.
//  3 BRANCH_PENALTY=3, BR_MODE=0, branch in ID -> exactly 3 cycles IF/ID en=0, stall_cycles +3.
//  4 i_data_ready=0 for 4 cycles during BR_WAIT -> all enables 0, and the penalty resumes with cnt unchanged.
//  5 BR_MODE=1, i_ex_br_taken with load-use present -> o_flush=1 and IF en=1 for one cycle.
//  6 Reset asserted mid-BR_WAIT, CNT_W=4 saturation -> FSM RUN at release; counter sticks at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard unit: forwarding selects, branch FSM states
// and the stall-cause encoding used by the priority encoder.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_MA = 2'b10,
        FWD_WB = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        BR_RUN  = 1'b0,
        BR_WAIT = 1'b1
    } br_state_e;

    typedef enum logic [2:0] {
        NONE       = 3'd0,
        MEM_WAIT   = 3'd1,
        LOAD_USE   = 3'd2,
        BRANCH     = 3'd3,
        FETCH_WAIT = 3'd4
    } stall_cause_e;

    // Holds the 1..7 branch penalty.
    localparam int unsigned BR_CNT_W = 3;

    // Causes that freeze IF/ID and push a bubble into EX.
    function automatic logic holds_front(stall_cause_e cause);
        return (cause == LOAD_USE) || (cause == BRANCH) || (cause == FETCH_WAIT);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Resolves one ID source register against the EX/MA/WB destinations into an
// operand-mux select plus a stall request (load-use, or any RAW when not forwarding).
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W  = 5,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic [REG_W-1:0] i_rs,
    input  logic             i_use,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_we,
    input  logic             i_ex_is_load,
    input  logic [REG_W-1:0] i_ma_rd,
    input  logic             i_ma_we,
    input  logic [REG_W-1:0] i_wb_rd,
    input  logic             i_wb_we,
    output fwd_sel_e         o_sel,
    output logic             o_stall
);

    logic rs_live;
    logic ex_hit;
    logic ma_hit;
    logic wb_hit;

    // x0 is hard-wired zero, so it never participates in a dependency.
    assign rs_live = i_use && (i_rs != '0);
    assign ex_hit  = rs_live && i_ex_we && (i_ex_rd == i_rs);
    assign ma_hit  = rs_live && i_ma_we && (i_ma_rd == i_rs);
    assign wb_hit  = rs_live && i_wb_we && (i_wb_rd == i_rs);

    always_comb begin
        o_sel   = FWD_RF;
        o_stall = 1'b0;
        if (FWD_EN) begin
            // Youngest producer wins; a load in EX has no data yet.
            if (ex_hit) begin
                if (i_ex_is_load) begin
                    o_stall = 1'b1;
                end else begin
                    o_sel = FWD_EX;
                end
            end else if (ma_hit) begin
                o_sel = FWD_MA;
            end else if (wb_hit) begin
                o_sel = FWD_WB;
            end
        end else begin
            // Without bypass paths WB is covered by regfile write-through only.
            o_stall = ex_hit || ma_hit || (wb_hit && 1'b0);
        end
    end

endmodule

// File: rtl/hazard_unit_fwd.sv
// 5-stage pipeline hazard unit: forwarding selects, load-use/RAW stalls, branch
// penalty FSM or predict-not-taken flush, and a saturating IF-stall counter.
module hazard_unit_fwd
    import hazard_pkg::*;
#(
    parameter int unsigned NREG           = 32,
    parameter bit          FWD_EN         = 1'b1,
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter bit          BR_MODE        = 1'b0,
    parameter int unsigned CNT_W          = 32,
    localparam int unsigned REG_W         = $clog2(NREG)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_instr_ready,
    input  logic             i_data_ready,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic             i_id_branch,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_ma_rd,
    input  logic [REG_W-1:0] i_wb_rd,
    input  logic             i_ex_we,
    input  logic             i_ma_we,
    input  logic             i_wb_we,
    input  logic             i_ex_is_load,
    input  logic             i_ex_br_taken,
    output logic             o_if_clk_en,
    output logic             o_id_clk_en,
    output logic             o_ex_clk_en,
    output logic             o_ma_clk_en,
    output logic             o_wb_clk_en,
    output logic             o_ex_bubble,
    output logic             o_flush,
    output logic [1:0]       o_fwd_rs1,
    output logic [1:0]       o_fwd_rs2,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam logic [BR_CNT_W-1:0] PENALTY = BR_CNT_W'(BRANCH_PENALTY);

    fwd_sel_e sel_rs1;
    fwd_sel_e sel_rs2;
    logic     stall_rs1;
    logic     stall_rs2;

    hazard_fwd_sel #(
        .REG_W  (REG_W),
        .FWD_EN (FWD_EN)
    ) u_fwd_rs1 (
        .i_rs         (i_id_rs1),
        .i_use        (i_id_use_rs1),
        .i_ex_rd      (i_ex_rd),
        .i_ex_we      (i_ex_we),
        .i_ex_is_load (i_ex_is_load),
        .i_ma_rd      (i_ma_rd),
        .i_ma_we      (i_ma_we),
        .i_wb_rd      (i_wb_rd),
        .i_wb_we      (i_wb_we),
        .o_sel        (sel_rs1),
        .o_stall      (stall_rs1)
    );

    hazard_fwd_sel #(
        .REG_W  (REG_W),
        .FWD_EN (FWD_EN)
    ) u_fwd_rs2 (
        .i_rs         (i_id_rs2),
        .i_use        (i_id_use_rs2),
        .i_ex_rd      (i_ex_rd),
        .i_ex_we      (i_ex_we),
        .i_ex_is_load (i_ex_is_load),
        .i_ma_rd      (i_ma_rd),
        .i_ma_we      (i_ma_we),
        .i_wb_rd      (i_wb_rd),
        .i_wb_we      (i_wb_we),
        .o_sel        (sel_rs2),
        .o_stall      (stall_rs2)
    );

    br_state_e           state_q, state_d;
    logic [BR_CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic         mem_wait;
    logic         data_hazard;
    logic         flush_req;
    logic         br_entry;
    stall_cause_e cause;

    assign mem_wait    = !i_data_ready;
    assign data_hazard = stall_rs1 || stall_rs2;
    assign flush_req   = BR_MODE && i_ex_br_taken && !mem_wait;
    assign br_entry    = !BR_MODE && (state_q == BR_RUN) && i_id_branch;

    // Priority encoder; a branch entering from ID advances normally even
    // if the next fetch is not ready, since BR_WAIT holds IF anyway.
    always_comb begin
        cause = NONE;
        if (mem_wait) begin
            cause = MEM_WAIT;
        end else if (data_hazard) begin
            cause = LOAD_USE;
        end else if (state_q == BR_WAIT) begin
            cause = BRANCH;
        end else if (!br_entry && !i_instr_ready) begin
            cause = FETCH_WAIT;
        end
    end

    always_comb begin
        o_if_clk_en = 1'b1;
        o_id_clk_en = 1'b1;
        o_ex_clk_en = 1'b1;
        o_ma_clk_en = 1'b1;
        o_wb_clk_en = 1'b1;
        o_ex_bubble = 1'b0;
        o_flush     = 1'b0;
        if (i_rst || (cause == MEM_WAIT)) begin
            o_if_clk_en = 1'b0;
            o_id_clk_en = 1'b0;
            o_ex_clk_en = 1'b0;
            o_ma_clk_en = 1'b0;
            o_wb_clk_en = 1'b0;
        end else if (flush_req) begin
            // Taken branch discards ID (even a load-use victim) and fetches the target.
            o_ex_bubble = 1'b1;
            o_flush     = 1'b1;
        end else if (holds_front(cause)) begin
            o_if_clk_en = 1'b0;
            o_id_clk_en = 1'b0;
            o_ex_bubble = 1'b1;
        end
    end

    assign o_fwd_rs1 = i_rst ? FWD_RF : sel_rs1;
    assign o_fwd_rs2 = i_rst ? FWD_RF : sel_rs2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!mem_wait) begin
            unique case (state_q)
                BR_RUN: begin
                    if (br_entry && !data_hazard) begin
                        state_d = BR_WAIT;
                        cnt_d   = PENALTY;
                    end
                end
                BR_WAIT: begin
                    if (cnt_q <= BR_CNT_W'(1)) begin
                        state_d = BR_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = BR_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!o_if_clk_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign o_stall_cycles = stall_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= BR_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit_fwd.sv
// Bench for hazard_unit_fwd: three configurations share one stimulus stream and are
// checked every cycle against a rule-level model, plus hand-computed spot checks.
module tb_hazard_unit_fwd;

    localparam int CFG_FWD [3] = '{1, 1, 0};
    localparam int CFG_PEN [3] = '{3, 1, 2};
    localparam int CFG_BRM [3] = '{0, 1, 0};
    localparam int CFG_CW  [3] = '{4, 8, 8};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_ready = 1'b1;
    logic       data_ready = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0, ma_rd = '0, wb_rd = '0;
    logic       use1 = 1'b0, use2 = 1'b0, id_branch = 1'b0;
    logic       ex_we = 1'b0, ma_we = 1'b0, wb_we = 1'b0, ex_load = 1'b0, br_taken = 1'b0;

    logic       if_en [3];
    logic       id_en [3];
    logic       ex_en [3];
    logic       ma_en [3];
    logic       wb_en [3];
    logic       bub   [3];
    logic       fl    [3];
    logic [1:0] f1    [3];
    logic [1:0] f2    [3];
    logic [3:0] cnt_a;
    logic [7:0] cnt_b;
    logic [7:0] cnt_c;

    int n_chk  = 0;
    int n_fail = 0;
    int rem    [3] = '{0, 0, 0};
    int stalls [3] = '{0, 0, 0};

    typedef struct {
        logic [4:0] en;
        logic       bub;
        logic       fl;
        logic [1:0] s1;
        logic [1:0] s2;
        int         cnt;
        logic       hz;
    } obs_t;

    always #5 clk = ~clk;

    hazard_unit_fwd #(.NREG(32), .FWD_EN(1'b1), .BRANCH_PENALTY(3), .BR_MODE(1'b0), .CNT_W(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_instr_ready(instr_ready), .i_data_ready(data_ready),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
        .i_id_branch(id_branch), .i_ex_rd(ex_rd), .i_ma_rd(ma_rd), .i_wb_rd(wb_rd),
        .i_ex_we(ex_we), .i_ma_we(ma_we), .i_wb_we(wb_we), .i_ex_is_load(ex_load),
        .i_ex_br_taken(br_taken), .o_if_clk_en(if_en[0]), .o_id_clk_en(id_en[0]),
        .o_ex_clk_en(ex_en[0]), .o_ma_clk_en(ma_en[0]), .o_wb_clk_en(wb_en[0]),
        .o_ex_bubble(bub[0]), .o_flush(fl[0]), .o_fwd_rs1(f1[0]), .o_fwd_rs2(f2[0]),
        .o_stall_cycles(cnt_a)
    );

    hazard_unit_fwd #(.NREG(32), .FWD_EN(1'b1), .BRANCH_PENALTY(1), .BR_MODE(1'b1), .CNT_W(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_instr_ready(instr_ready), .i_data_ready(data_ready),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
        .i_id_branch(id_branch), .i_ex_rd(ex_rd), .i_ma_rd(ma_rd), .i_wb_rd(wb_rd),
        .i_ex_we(ex_we), .i_ma_we(ma_we), .i_wb_we(wb_we), .i_ex_is_load(ex_load),
        .i_ex_br_taken(br_taken), .o_if_clk_en(if_en[1]), .o_id_clk_en(id_en[1]),
        .o_ex_clk_en(ex_en[1]), .o_ma_clk_en(ma_en[1]), .o_wb_clk_en(wb_en[1]),
        .o_ex_bubble(bub[1]), .o_flush(fl[1]), .o_fwd_rs1(f1[1]), .o_fwd_rs2(f2[1]),
        .o_stall_cycles(cnt_b)
    );

    hazard_unit_fwd #(.NREG(32), .FWD_EN(1'b0), .BRANCH_PENALTY(2), .BR_MODE(1'b0), .CNT_W(8)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_instr_ready(instr_ready), .i_data_ready(data_ready),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
        .i_id_branch(id_branch), .i_ex_rd(ex_rd), .i_ma_rd(ma_rd), .i_wb_rd(wb_rd),
        .i_ex_we(ex_we), .i_ma_we(ma_we), .i_wb_we(wb_we), .i_ex_is_load(ex_load),
        .i_ex_br_taken(br_taken), .o_if_clk_en(if_en[2]), .o_id_clk_en(id_en[2]),
        .o_ex_clk_en(ex_en[2]), .o_ma_clk_en(ma_en[2]), .o_wb_clk_en(wb_en[2]),
        .o_ex_bubble(bub[2]), .o_flush(fl[2]), .o_fwd_rs1(f1[2]), .o_fwd_rs2(f2[2]),
        .o_stall_cycles(cnt_c)
    );

    // {stall, sel} for one source register under configuration k.
    function automatic logic [2:0] fwd_rule(int k, logic [4:0] rs, logic u);
        logic ex, ma, wb;
        if (!u || rs == 5'd0) return 3'b000;
        ex = ex_we && (ex_rd == rs);
        ma = ma_we && (ma_rd == rs);
        wb = wb_we && (wb_rd == rs);
        if (CFG_FWD[k] == 0) return {ex || ma, 2'b00};
        if (ex) return ex_load ? 3'b100 : 3'b001;
        if (ma) return 3'b010;
        if (wb) return 3'b011;
        return 3'b000;
    endfunction

    function automatic obs_t model_of(int k);
        obs_t e;
        logic [2:0] r1, r2;
        logic fetch_hold;
        r1 = fwd_rule(k, id_rs1, use1);
        r2 = fwd_rule(k, id_rs2, use2);
        e.hz  = r1[2] || r2[2];
        e.s1  = rst ? 2'b00 : r1[1:0];
        e.s2  = rst ? 2'b00 : r2[1:0];
        e.cnt = rst ? 0 : stalls[k];
        e.bub = 1'b0;
        e.fl  = 1'b0;
        e.en  = 5'b11111;
        fetch_hold = !instr_ready && !(CFG_BRM[k] == 0 && id_branch);
        if (rst || !data_ready) begin
            e.en = 5'b00000;
        end else if (CFG_BRM[k] == 1 && br_taken) begin
            e.bub = 1'b1;
            e.fl  = 1'b1;
        end else if (e.hz || rem[k] > 0 || fetch_hold) begin
            e.en  = 5'b00111;
            e.bub = 1'b1;
        end
        return e;
    endfunction

    function automatic obs_t dut_of(int k);
        obs_t g;
        g.en  = {if_en[k], id_en[k], ex_en[k], ma_en[k], wb_en[k]};
        g.bub = bub[k];
        g.fl  = fl[k];
        g.s1  = f1[k];
        g.s2  = f2[k];
        g.cnt = (k == 0) ? int'(cnt_a) : (k == 1) ? int'(cnt_b) : int'(cnt_c);
        g.hz  = 1'b0;
        return g;
    endfunction

    task automatic chk(input string name, input int k, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got=%0d expected=%0d", name, k, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            obs_t e, g;
            e = model_of(k);
            g = dut_of(k);
            chk("enables", k, int'(g.en), int'(e.en));
            chk("bubble", k, int'(g.bub), int'(e.bub));
            chk("flush", k, int'(g.fl), int'(e.fl));
            chk("fwd_rs1", k, int'(g.s1), int'(e.s1));
            chk("fwd_rs2", k, int'(g.s2), int'(e.s2));
            chk("stall_cycles", k, g.cnt, e.cnt);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            obs_t e;
            e = model_of(k);
            if (rst) begin
                rem[k]    = 0;
                stalls[k] = 0;
            end else begin
                if (!e.en[4] && stalls[k] < (1 << CFG_CW[k]) - 1) stalls[k] = stalls[k] + 1;
                if (data_ready) begin
                    if (rem[k] > 0) rem[k] = rem[k] - 1;
                    else if (CFG_BRM[k] == 0 && id_branch && !e.hz) rem[k] = CFG_PEN[k];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic clear_ops();
        use1 = 1'b0; use2 = 1'b0; id_rs1 = '0; id_rs2 = '0;
        ex_we = 1'b0; ma_we = 1'b0; wb_we = 1'b0; ex_load = 1'b0;
        ex_rd = '0; ma_rd = '0; wb_rd = '0; id_branch = 1'b0; br_taken = 1'b0;
    endtask

    initial begin
        // Reset with a live forwarding match on the inputs.
        id_rs1 = 5'd5; use1 = 1'b1; ex_rd = 5'd5; ex_we = 1'b1;
        look();
        chk("rst_if_en", 0, int'(if_en[0]), 0);
        chk("rst_wb_en", 0, int'(wb_en[0]), 0);
        chk("rst_fwd_rs1", 0, int'(f1[0]), 0);
        chk("rst_cnt", 0, int'(cnt_a), 0);
        tick(); rst = 1'b0;
        look();
        chk("t1_fwd_rs1", 0, int'(f1[0]), 1);
        chk("t1_if_en", 0, int'(if_en[0]), 1);
        chk("t1_bubble", 0, int'(bub[0]), 0);
        chk("t1_nofwd_sel", 2, int'(f1[2]), 0);
        chk("t1_nofwd_stall", 2, int'(if_en[2]), 0);

        // Load-use on rs2, then the load forwards from MA.
        tick(); clear_ops();
        id_rs2 = 5'd7; use2 = 1'b1; ex_rd = 5'd7; ex_we = 1'b1; ex_load = 1'b1;
        look();
        chk("t2_lu_if_en", 0, int'(if_en[0]), 0);
        chk("t2_lu_ex_en", 0, int'(ex_en[0]), 1);
        chk("t2_lu_bubble", 0, int'(bub[0]), 1);
        chk("t2_lu_sel", 0, int'(f2[0]), 0);
        tick(); ex_we = 1'b0; ex_load = 1'b0; ex_rd = '0; ma_rd = 5'd7; ma_we = 1'b1;
        look();
        chk("t2_ma_sel", 0, int'(f2[0]), 2);
        chk("t2_ma_if_en", 0, int'(if_en[0]), 1);
        chk("t2_cnt", 0, int'(cnt_a), 1);
        tick(); ma_we = 1'b0; wb_rd = 5'd7; wb_we = 1'b1;
        look();
        chk("wb_sel", 0, int'(f2[0]), 3);
        chk("wb_nofwd_run", 2, int'(if_en[2]), 1);
        tick(); ex_rd = 5'd7; ex_we = 1'b1; ma_we = 1'b1;
        look();
        chk("youngest_sel", 0, int'(f2[0]), 1);
        tick(); id_rs2 = 5'd0; ex_rd = 5'd0; ma_rd = 5'd0; wb_rd = 5'd0;
        look();
        chk("x0_sel", 0, int'(f2[0]), 0);
        chk("x0_nofwd_run", 2, int'(if_en[2]), 1);

        // Branch penalty of three on dut_a; branch held during the wait is ignored.
        tick(); clear_ops(); id_branch = 1'b1;
        look();
        chk("br_entry_if_en", 0, int'(if_en[0]), 1);
        tick();
        look();
        chk("br_w1_if_en", 0, int'(if_en[0]), 0);
        chk("br_w1_bubble", 0, int'(bub[0]), 1);
        tick(); id_branch = 1'b0;
        look();
        chk("br_w2_if_en", 0, int'(if_en[0]), 0);
        tick();
        look();
        chk("br_w3_if_en", 0, int'(if_en[0]), 0);
        tick();
        look();
        chk("br_done_if_en", 0, int'(if_en[0]), 1);
        chk("br_cnt", 0, int'(cnt_a), 4);

        // Memory wait inside BR_WAIT freezes the penalty.
        tick(); id_branch = 1'b1;
        tick(); id_branch = 1'b0;
        look();
        chk("mw_pre_if_en", 0, int'(if_en[0]), 0);
        for (int i = 0; i < 4; i++) begin
            tick(); data_ready = 1'b0;
            look();
            chk("mw_ex_en", 0, int'(ex_en[0]), 0);
            chk("mw_bubble", 0, int'(bub[0]), 0);
        end
        tick(); data_ready = 1'b1;
        look();
        chk("mw_resume1", 0, int'(if_en[0]), 0);
        tick();
        look();
        chk("mw_resume2", 0, int'(if_en[0]), 0);
        tick();
        look();
        chk("mw_done", 0, int'(if_en[0]), 1);

        // Taken branch with a pending load-use: flush wins on dut_b.
        tick(); ex_rd = 5'd9; ex_we = 1'b1; ex_load = 1'b1; id_rs1 = 5'd9; use1 = 1'b1;
        br_taken = 1'b1;
        look();
        chk("fl_flush", 1, int'(fl[1]), 1);
        chk("fl_if_en", 1, int'(if_en[1]), 1);
        chk("fl_bubble", 1, int'(bub[1]), 1);
        chk("fl_mode0_lu", 0, int'(if_en[0]), 0);
        tick(); data_ready = 1'b0;
        look();
        chk("fl_frozen", 1, int'(fl[1]), 0);
        tick(); data_ready = 1'b1;
        look();
        chk("fl_after_wait", 1, int'(fl[1]), 1);
        tick(); clear_ops();
        look();
        chk("fl_clear", 1, int'(fl[1]), 0);

        // Saturate the 4-bit counter, then reset in the middle of BR_WAIT.
        for (int i = 0; i < 16; i++) begin
            tick(); instr_ready = 1'b0;
        end
        tick(); instr_ready = 1'b1;
        look();
        chk("sat_cnt", 0, int'(cnt_a), 15);
        tick(); id_branch = 1'b1;
        tick(); id_branch = 1'b0;
        look();
        chk("rs_wait_if_en", 0, int'(if_en[0]), 0);
        tick(); rst = 1'b1;
        look();
        chk("rs_cnt_cleared", 0, int'(cnt_a), 0);
        tick(); rst = 1'b0;
        look();
        chk("rs_no_residual", 0, int'(if_en[0]), 1);
        chk("rs_no_bubble", 0, int'(bub[0]), 0);
        tick();
        look();
        chk("rs_cnt_after", 0, int'(cnt_a), 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
